instr_sequencer: RTL

- Program sequencer in front of the single-cycle cpu datapath.
- Holds a program counter and fetches packed instruction words from an instruction memory over a variable-latency req/valid handshake.
- Unpacks each word into the datapath control fields and asserts register write-enable for exactly one cycle per instruction.
- Stops on EBREAK. Supports free-run and single-step modes for bench and debug use.

---
 rtl/instr_sequencer_if.sv | 28 ++
 rtl/instr_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: variable-latency req/valid handshake.
// The sequencer is the master (drives req/addr); the memory is the slave.
interface instr_sequencer_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned IMM_W = 12,
  parameter int unsigned PC_W  = 8
);
  localparam int unsigned WordW = OP_W + IMM_W + 17;

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_valid;
  logic [WordW-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer in front of the single-cycle datapath.
// Fetches packed words {op, dst, src1, has_immediate, src2, imm, ebreak} over a
// req/valid bus, strobes reg_write_enable for one cycle per instruction and stops
// on EBREAK. Supports free-run and single-step operation.
// Optional feature macro: PERF_COUNTERS_EN (retired / stall_cycles counters).
module instr_sequencer #(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned IMM_W    = 12,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  instr_sequencer_if.master imem,
  output logic [OP_W-1:0]   op,
  output logic [4:0]        dst,
  output logic [4:0]        src1,
  output logic [4:0]        src2,
  output logic              has_immediate,
  output logic [IMM_W-1:0]  imm,
  output logic              reg_write_enable,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       retired,
  output logic [31:0]       stall_cycles
);

  localparam int unsigned WordW = OP_W + IMM_W + 17;
  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StPause,
    StHalted
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  // The ebreak bit only steers the FSM, so the instruction register omits it.
  logic [WordW-1:1] ir_q, ir_d;
  logic             start_accepted;

  assign start_accepted = start && ((state_q == StIdle) || (state_q == StHalted));

  // Next-state, program counter and instruction-register load.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start_accepted) begin
          pc_d    = ResetPc;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_data[WordW-1:1];
          state_d = imem.imem_data[0] ? StHalted : StExec;
        end
      end
      StExec: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = step_mode ? StPause : StFetch;
      end
      StPause: begin
        if (step) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;

  assign op            = ir_q[WordW-1:IMM_W+17];
  assign dst           = ir_q[IMM_W+16:IMM_W+12];
  assign src1          = ir_q[IMM_W+11:IMM_W+7];
  assign has_immediate = ir_q[IMM_W+6];
  assign src2          = ir_q[IMM_W+5:IMM_W+1];
  assign imm           = ir_q[IMM_W:1];

  assign reg_write_enable = (state_q == StExec);
  assign pc               = pc_q;
  assign busy             = (state_q == StFetch) || (state_q == StExec) || (state_q == StPause);
  assign halted           = (state_q == StHalted);

`ifdef PERF_COUNTERS_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  // Saturating performance counters, cleared by an accepted start.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (start_accepted) begin
      retired_d = '0;
      stall_d   = '0;
    end else begin
      if ((state_q == StExec) && (retired_q != '1)) begin
        retired_d = retired_q + 32'd1;
      end
      if ((state_q == StFetch) && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`else
  assign retired      = '0;
  assign stall_cycles = '0;
`endif

endmodule
